// File: rtl/knn_pkg.sv
// Shared constants for the kNN top-K sorter and the downstream majority voter.
// Both sides unpack sorted_list with these widths and the same SENTINEL value.
package knn_pkg;

  localparam int DIST_W  = 18;
  localparam int CLASS_W = 2;
  localparam int ENTRY_W = DIST_W + CLASS_W;
  localparam int K_MAX   = 5;

  localparam logic [ENTRY_W-1:0] SENTINEL = {{DIST_W{1'b1}}, {CLASS_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/topk_insert_slot.sv
// One rank of the top-K insertion array.
// Each accepted sample either leaves the rank alone, writes the sample here, or shifts the entry down from the rank above.
module topk_insert_slot #(
  parameter int DIST_W  = 18,
  parameter int CLASS_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       accept,
  input  logic                       clear,
  input  logic [DIST_W+CLASS_W-1:0]  new_entry,
  input  logic [DIST_W+CLASS_W-1:0]  prev_entry,
  input  logic                       prev_lt,
  output logic                       lt,
  output logic [DIST_W+CLASS_W-1:0]  entry_d,
  output logic [DIST_W+CLASS_W-1:0]  entry_q
);

  localparam int ENTRY_W = DIST_W + CLASS_W;
  localparam logic [ENTRY_W-1:0] SENT = {{DIST_W{1'b1}}, {CLASS_W{1'b0}}};

  // Strictly-less keeps an equal existing entry at the better rank.
  assign lt = new_entry[ENTRY_W-1:CLASS_W] < entry_q[ENTRY_W-1:CLASS_W];

  always_comb begin
    entry_d = entry_q;
    if (accept) begin
      if (prev_lt)
        entry_d = prev_entry;
      else if (lt)
        entry_d = new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      entry_q <= SENT;
    else if (clear)
      entry_q <= SENT;
    else
      entry_q <= entry_d;
  end

endmodule

// File: rtl/knn_topk_sorter.sv
// Streaming top-K selector: keeps the K smallest (distance, class) samples of a frame
// and publishes them rank-ordered with a one-cycle start pulse at end of frame.
module knn_topk_sorter #(
  parameter int DIST_W  = knn_pkg::DIST_W,
  parameter int CLASS_W = knn_pkg::CLASS_W,
  parameter int K_MAX   = knn_pkg::K_MAX
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DIST_W-1:0]                    in_dist,
  input  logic [CLASS_W-1:0]                   in_class,
  input  logic                                 in_last,
  output logic [K_MAX*(DIST_W+CLASS_W)-1:0]    sorted_list,
  output logic                                 start,
  output logic [15:0]                          sample_count
);

  import knn_pkg::*;

  localparam int EW = DIST_W + CLASS_W;
  localparam logic [EW-1:0] SENT = {{DIST_W{1'b1}}, {CLASS_W{1'b0}}};

  state_t state_q, state_d;

  logic              accept;
  logic              last_acc;
  logic [EW-1:0]     new_entry;
  logic [EW-1:0]     slot_q [K_MAX];
  logic [EW-1:0]     slot_d [K_MAX];
  logic [K_MAX-1:0]  lt;
  logic [K_MAX*EW-1:0] list_d;

  assign in_ready  = !rst && (state_q != ST_EMIT);
  assign accept    = in_valid && in_ready;
  assign last_acc  = accept && in_last;
  assign new_entry = {in_dist, in_class};
  assign start     = (state_q == ST_EMIT);

  for (genvar i = 0; i < K_MAX; i++) begin : g_slot
    logic          prev_lt;
    logic [EW-1:0] prev_entry;
    if (i == 0) begin : g_first
      assign prev_lt    = 1'b0;
      assign prev_entry = new_entry;
    end else begin : g_rest
      assign prev_lt    = lt[i-1];
      assign prev_entry = slot_q[i-1];
    end

    topk_insert_slot #(
      .DIST_W  (DIST_W),
      .CLASS_W (CLASS_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .accept     (accept),
      .clear      (last_acc),
      .new_entry  (new_entry),
      .prev_entry (prev_entry),
      .prev_lt    (prev_lt),
      .lt         (lt[i]),
      .entry_d    (slot_d[i]),
      .entry_q    (slot_q[i])
    );
  end

  always_comb begin
    list_d = '0;
    for (int unsigned i = 0; i < K_MAX; i++)
      list_d[i*EW +: EW] = slot_d[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = in_last ? ST_EMIT : ST_ACCUM;
      ST_ACCUM: if (last_acc) state_d = ST_EMIT;
      ST_EMIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The list is captured with the last sample already inserted, so start and
  // sorted_list appear together in the cycle after the final accept while the slots clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sorted_list  <= {K_MAX{SENT}};
      sample_count <= '0;
    end else begin
      state_q <= state_d;
      if (last_acc)
        sorted_list <= list_d;
      if (accept) begin
        if (state_q == ST_IDLE)
          sample_count <= 16'd1;
        else if (sample_count != '1)
          sample_count <= sample_count + 16'd1;
      end
    end
  end

endmodule
